// File: rtl/sc_fila_clear.sv
// Row-clear engine: latches the playfield, drops full rows bottom-up with zero fill at the top, and reports how many were removed.
// Latency is 8+k cycles from the start edge to done for k removed rows; there is no backpressure, and a start seen outside IDLE is dropped.
module sc_fila_clear #(
    parameter int NUMBER_ROWS      = 8,
    parameter int NUMBER_DATAWIDTH = 8
) (
    input  logic                                     SC_FILA_CLEAR_CLOCK_50,
    input  logic                                     SC_FILA_CLEAR_RESET_InHigh,
    input  logic                                     SC_FILA_CLEAR_start_InLow,
    input  logic [NUMBER_ROWS*NUMBER_DATAWIDTH-1:0] SC_FILA_CLEAR_matrix_InBus,
    output logic [NUMBER_ROWS*NUMBER_DATAWIDTH-1:0] SC_FILA_CLEAR_matrix_OutBus,
    output logic [3:0]                               SC_FILA_CLEAR_count_OutBus,
    output logic                                     SC_FILA_CLEAR_busy_Out,
    output logic                                     SC_FILA_CLEAR_done_Out
);

    localparam int              MW       = NUMBER_ROWS * NUMBER_DATAWIDTH;
    localparam int              RW       = $clog2(NUMBER_ROWS);
    localparam logic [RW-1:0]   LAST_ROW = RW'(NUMBER_ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [MW-1:0]               r_work;
    logic [RW-1:0]               r_row;
    logic [3:0]                  r_count;
    logic [MW-1:0]               r_matrix_out;
    logic [3:0]                  r_count_out;

    logic                        w_start;
    logic [NUMBER_DATAWIDTH-1:0] w_row_dat;
    logic                        w_row_full;
    logic                        w_scan_end;
    logic [MW-1:0]               w_work_shift;
    logic [MW-1:0]               w_work_clr;

    assign w_start      = ~SC_FILA_CLEAR_start_InLow;
    assign w_row_full   = &w_row_dat;
    assign w_scan_end   = (r_state == ST_SCAN) && !w_row_full && (r_row == LAST_ROW);
    assign w_work_shift = {{NUMBER_DATAWIDTH{1'b0}}, r_work[MW-1:NUMBER_DATAWIDTH]};

    always_comb begin
        w_row_dat = '0;
        for (int i = 0; i < NUMBER_ROWS; i++) begin
            if (r_row == RW'(i)) begin
                w_row_dat = r_work[i*NUMBER_DATAWIDTH +: NUMBER_DATAWIDTH];
            end
        end
    end

    // Rows below the current index stay put; the current row and everything above take the row one higher.
    always_comb begin
        w_work_clr = r_work;
        for (int i = 0; i < NUMBER_ROWS; i++) begin
            if (RW'(i) >= r_row) begin
                w_work_clr[i*NUMBER_DATAWIDTH +: NUMBER_DATAWIDTH] =
                    w_work_shift[i*NUMBER_DATAWIDTH +: NUMBER_DATAWIDTH];
            end
        end
    end

    always_ff @(posedge SC_FILA_CLEAR_CLOCK_50) begin
        if (SC_FILA_CLEAR_RESET_InHigh) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start)    w_state_nxt = ST_SCAN;
            ST_SCAN: if (w_scan_end) w_state_nxt = ST_DONE;
            ST_DONE:                 w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge SC_FILA_CLEAR_CLOCK_50) begin
        if (SC_FILA_CLEAR_RESET_InHigh) begin
            r_work       <= '0;
            r_row        <= '0;
            r_count      <= '0;
            r_matrix_out <= '0;
            r_count_out  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_work  <= SC_FILA_CLEAR_matrix_InBus;
                        r_row   <= '0;
                        r_count <= '0;
                    end
                end
                ST_SCAN: begin
                    // A full row keeps the index so the row that slid down gets checked next.
                    if (w_row_full) begin
                        r_work  <= w_work_clr;
                        r_count <= r_count + 4'd1;
                    end else if (r_row != LAST_ROW) begin
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_matrix_out <= r_work;
                        r_count_out  <= r_count;
                    end
                end
                default: ;
            endcase
        end
    end

    assign SC_FILA_CLEAR_matrix_OutBus = r_matrix_out;
    assign SC_FILA_CLEAR_count_OutBus  = r_count_out;
    assign SC_FILA_CLEAR_busy_Out      = (r_state == ST_SCAN);
    assign SC_FILA_CLEAR_done_Out      = (r_state == ST_DONE);

endmodule

// File: tb/tb_sc_fila_clear.sv
// Bench for sc_fila_clear: expected results are queued when a pass is started and compared when done pulses.
module tb_sc_fila_clear;

    logic        clk;
    logic        rst;
    logic        start_n;
    logic [63:0] mat_in;
    logic [63:0] mat_out;
    logic [3:0]  cnt_out;
    logic        busy;
    logic        done;

    int n_chk;
    int n_fail;

    typedef struct {
        logic [63:0] mat;
        int          cnt;
    } exp_t;

    exp_t sb[$];

    sc_fila_clear #(
        .NUMBER_ROWS      (8),
        .NUMBER_DATAWIDTH (8)
    ) dut (
        .SC_FILA_CLEAR_CLOCK_50      (clk),
        .SC_FILA_CLEAR_RESET_InHigh  (rst),
        .SC_FILA_CLEAR_start_InLow   (start_n),
        .SC_FILA_CLEAR_matrix_InBus  (mat_in),
        .SC_FILA_CLEAR_matrix_OutBus (mat_out),
        .SC_FILA_CLEAR_count_OutBus  (cnt_out),
        .SC_FILA_CLEAR_busy_Out      (busy),
        .SC_FILA_CLEAR_done_Out      (done)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: keep the non-full rows in order, pack them at the bottom, zero the rest.
    function automatic void model(input logic [63:0] m, output logic [63:0] o, output int k);
        logic [7:0] row;
        int         w;
        o = '0;
        k = 0;
        w = 0;
        for (int i = 0; i < 8; i++) begin
            row = m[i*8 +: 8];
            if (row == 8'hFF) begin
                k++;
            end else begin
                o[w*8 +: 8] = row;
                w++;
            end
        end
    endfunction

    task automatic run_pass(input string tag, input logic [63:0] m,
                            input int inj_at, input logic [63:0] inj_m);
        exp_t e;
        exp_t got;
        int   busy_n;
        int   lat;
        int   extra;
        bit   seen;
        model(m, e.mat, e.cnt);
        sb.push_back(e);
        @(negedge clk);
        start_n = 1'b0;
        mat_in  = m;
        @(posedge clk);
        #1;
        start_n = 1'b1;
        mat_in  = ~m;
        busy_n = 0;
        lat    = 0;
        seen   = 1'b0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge clk);
            if (n == inj_at) begin
                start_n = 1'b0;
                mat_in  = inj_m;
            end else begin
                start_n = 1'b1;
            end
            if (busy) busy_n++;
            if (done) begin
                seen = 1'b1;
                lat  = n - 1;
            end
        end
        start_n = 1'b1;
        got = sb.pop_front();
        if (!seen) begin
            chk({tag, "_done_timeout"}, 64'd0, 64'd1);
        end else begin
            chk({tag, "_mat"},  mat_out, got.mat);
            chk({tag, "_cnt"},  64'(cnt_out), 64'(got.cnt));
            chk({tag, "_lat"},  64'(lat), 64'(8 + got.cnt));
            chk({tag, "_busy"}, 64'(busy_n), 64'(8 + got.cnt));
            @(negedge clk);
            chk({tag, "_done_1cyc"}, 64'(done), 64'd0);
            extra = 0;
            for (int n = 0; n < 4; n++) begin
                @(negedge clk);
                if (done || busy) extra++;
            end
            chk({tag, "_quiet"}, 64'(extra), 64'd0);
            chk({tag, "_hold"},  mat_out, got.mat);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] rm;
        logic [7:0]  row;
        int          dcnt;
        n_chk   = 0;
        n_fail  = 0;
        rst     = 1'b1;
        start_n = 1'b1;
        mat_in  = '0;
        repeat (2) @(negedge clk);
        chk("rst_mat",  mat_out, 64'd0);
        chk("rst_cnt",  64'(cnt_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_pass("nofull",   64'h0102_0408_1020_4080, 0, 64'd0);
        run_pass("bottom",   64'h0706_0504_0302_01FF, 0, 64'd0);
        chk("bottom_const", mat_out, 64'h0007_0605_0403_0201);
        run_pass("allfull",  64'hFFFF_FFFF_FFFF_FFFF, 0, 64'd0);
        run_pass("adjacent", 64'h81F0_FF00_FF0F_FFFF, 0, 64'd0);
        chk("adjacent_const", mat_out, 64'h0000_0000_81F0_000F);
        run_pass("ignore",   64'h0706_0504_0302_01FF, 3, 64'hFFFF_FFFF_FFFF_FFFF);

        // Abort a pass three cycles into SCAN.
        @(negedge clk);
        start_n = 1'b0;
        mat_in  = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        #1;
        start_n = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_mat",  mat_out, 64'd0);
        chk("abort_cnt",  64'(cnt_out), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        rst  = 1'b0;
        dcnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        chk("abort_no_done", 64'(dcnt), 64'd0);
        run_pass("fresh", 64'h0102_0408_1020_4080, 0, 64'd0);

        // Reset and start on the same edge: reset wins.
        @(negedge clk);
        rst     = 1'b1;
        start_n = 1'b0;
        mat_in  = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        rst     = 1'b0;
        start_n = 1'b1;
        chk("rst_start_busy", 64'(busy), 64'd0);
        chk("rst_start_mat",  mat_out, 64'd0);

        for (int t = 0; t < 6; t++) begin
            rm = '0;
            for (int i = 0; i < 8; i++) begin
                row = 8'($urandom);
                if ($urandom_range(0, 1) == 1) row = 8'hFF;
                rm[i*8 +: 8] = row;
            end
            run_pass($sformatf("rand%0d", t), rm, 0, 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sc_fila_clear.md
# sc_fila_clear

Row-clear engine for the 8x8 playfield matrix. On a start pulse it latches the playfield, scans rows bottom to top, removes every complete row (all ones), collapses the rows above it downward with zero fill at the top, and returns the cleaned matrix and the number of rows removed. It is the write-back end of the row-completion path: the row comparator flags full rows, and this block acts on them. A clear is one sequential pass over one playfield.

## Interface
Parameters:
- NUMBER_ROWS, 8, playfield rows; fixed at 8 for this release.
- NUMBER_DATAWIDTH, 8, bits per row.

Ports:
- SC_FILA_CLEAR_CLOCK_50  in  1  system clock, single clock domain.
- SC_FILA_CLEAR_RESET_InHigh  in  1  reset, synchronous, active-high.
- SC_FILA_CLEAR_start_InLow  in  1  start request, active-low. Sampled every rising edge; acted on only in IDLE.
- SC_FILA_CLEAR_matrix_InBus  in  64  playfield. Row r is bits [8r+7:8r]; row 0 is the bottom row.
- SC_FILA_CLEAR_matrix_OutBus  out  64  cleaned playfield, registered, same row packing.
- SC_FILA_CLEAR_count_OutBus  out  4  rows removed in the last pass, 0..8.
- SC_FILA_CLEAR_busy_Out  out  1  high while in SCAN.
- SC_FILA_CLEAR_done_Out  out  1  one-cycle pulse in DONE.

## Operation
- FSM states: IDLE, SCAN, DONE. Internal state: working matrix reg (64 bits), row index r (3 bits), count (4 bits).
- IDLE
  - start_InLow=0 at a rising edge: latch matrix_InBus into the working reg, set r=0 and count=0, go to SCAN.
  - start_InLow=1: stay in IDLE.
- SCAN: evaluates row r once per cycle.
  - Row r == 8'hFF (full):
    - rows r+1..7 move to r..6 and row 7 becomes 8'h00, all in one edge;
    - count increments;
    - r does not change, so the same index is re-checked next cycle with its new content.
  - Row r not full and r<7: r increments.
  - Row r not full and r==7: go to DONE.
  - Full row at r==7: row 7 is replaced by zeros and r stays 7. Row 7 is then non-full on the next cycle, so the scan always terminates.
  - All-zero rows are not cleared; only 8'hFF counts as full.
- DONE
  - done_Out=1 for exactly one cycle, then the FSM returns to IDLE.
- Output updates
  - matrix_OutBus and count_OutBus load from the working reg and count on the edge that enters DONE.
  - They hold until the edge that enters DONE at the end of the next pass.
- Requests outside IDLE: start_InLow is ignored in SCAN and DONE. Requests are not queued.
- matrix_InBus is sampled only on the start edge. Later changes do not affect a pass in progress.
- Arithmetic: count never exceeds 8, so 4 bits do not overflow. r never wraps, because the SCAN exit happens at r==7.

## Timing
- Reset (synchronous): FSM=IDLE, r=0, count=0, working reg=0, matrix_OutBus=64'h0, count_OutBus=4'h0, busy_Out=0, done_Out=0.
- Reset asserted mid-SCAN or in DONE:
  - the pass is aborted at that edge;
  - no done pulse is produced;
  - all outputs take their reset values.
- Reset and start asserted on the same edge: reset wins.
- Latency, counting from the edge that samples start (edge E0) with k full rows removed:
  - SCAN occupies the edges E1..E(8+k);
  - done_Out is high in the cycle after E(8+k);
  - busy_Out is high for exactly 8+k cycles;
  - minimum pass is 8 cycles (k=0); maximum is 16 cycles (k=8).
- Back-to-back passes: a new start is accepted in the IDLE cycle after DONE. The earliest accepted start is therefore 2 cycles after the last SCAN cycle.

## Test plan
- No full rows: matrix 64'h0102_0408_1020_4080, start → matrix_OutBus equals the input, count=0, done exactly 8 cycles after start, busy high for 8 cycles.
- Single full bottom row: rows 0..7 = FF,01,02,03,04,05,06,07 → out rows = 01,02,03,04,05,06,07,00, count=1, done after 9 cycles.
- All rows full: 64'hFFFF_FFFF_FFFF_FFFF → out = 0, count=8, busy high for 16 cycles, done after 16 cycles.
- Adjacent and alternating full rows: rows 0..7 = FF,FF,0F,FF,00,FF,F0,81 → out rows = 0F,00,F0,81,00,00,00,00, count=4.
- Start pulsed during SCAN with different matrix_InBus data → ignored; the result matches the first request; exactly one done pulse.
- Reset asserted 3 cycles into SCAN → the next cycle shows all outputs 0, busy=0, no done. A fresh start then completes normally.
